// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux8_rr_arbiter
// Description : Round-robin arbiter that owns the sel input of an 8:1 mux.
//               Registered one-hot grant, binary select and valid, with a
//               bounded hold time per owner while others are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid
);

  // Out-of-range values are clamped so the counter compare stays meaningful.
  localparam int         c_max_clamped = (MAX_HOLD < 1)   ? 1   :
                                         (MAX_HOLD > 255) ? 255 : MAX_HOLD;
  localparam logic [7:0] c_max_hold    = 8'(c_max_clamped);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr,   w_ptr_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [7:0] r_grant, w_grant_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  logic       r_valid, w_valid_nxt;

  logic       w_any;
  logic       w_own;
  logic       w_others;
  logic       w_issue;
  logic [2:0] w_pick;

  // First set bit of r scanning upward from p with wrap; o's own bit, when
  // p = o+1, is naturally visited last.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] win;
    win = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign w_any    = |req;
  assign w_own    = req[r_sel];
  assign w_others = |(req & ~r_grant);
  assign w_pick   = rr_pick(req, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_issue     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) w_issue = 1'b1;
      end
      S_GRANT: begin
        if (!w_own) begin
          if (w_others) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 8'h00;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = 8'd0;
          end
        end else if (!w_others) begin
          w_cnt_nxt = (r_cnt >= c_max_hold) ? c_max_hold : r_cnt + 8'd1;
        end else if (r_cnt < c_max_hold) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          w_issue = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 8'h00;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = 8'd0;
      end
    endcase

    // A new owner always restarts the hold count and moves the pointer past it.
    if (w_issue) begin
      w_state_nxt = S_GRANT;
      w_grant_nxt = 8'h01 << w_pick;
      w_sel_nxt   = w_pick;
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = 8'd1;
      w_ptr_nxt   = w_pick + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 3'd0;
      r_cnt   <= 8'd0;
      r_grant <= 8'h00;
      r_sel   <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux8_rr_arbiter
// Description : Self-checking bench for mux8_rr_arbiter with a behavioural
//               ownership model and randomized request traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the mux, where the next scan starts, hold length.
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_sel;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_winner(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endfunction

  function automatic void model_take(input logic [7:0] r);
    int w;
    w = find_winner(r, m_ptr);
    m_owner = w;
    m_sel   = w;
    m_cnt   = 1;
    m_ptr   = (w + 1) % 8;
  endfunction

  function automatic void model_step(input logic [7:0] r);
    logic own;
    logic others;
    if (m_owner < 0) begin
      if (r != 8'h00) model_take(r);
    end else begin
      own    = r[m_owner];
      others = (r & ~(8'h01 << m_owner)) != 8'h00;
      if (!own && !others) begin
        m_owner = -1;
        m_cnt   = 0;
      end else if (!own) begin
        model_take(r);
      end else if (!others) begin
        m_cnt = (m_cnt + 1 > MAX_HOLD) ? MAX_HOLD : m_cnt + 1;
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt = m_cnt + 1;
      end else begin
        model_take(r);
      end
    end
  endfunction

  function automatic logic [7:0] exp_grant();
    logic [7:0] one;
    one = 8'h01;
    return (m_owner < 0) ? 8'h00 : (one << m_owner);
  endfunction

  task automatic tick(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req   = 8'hFF;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({grant, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got grant=%h sel=%0d valid=%b, need 00/0/0", grant, sel, valid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({grant, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held: got grant=%h sel=%0d valid=%b, need 00/0/0", grant, sel, valid);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(8'h00);
      n_tests++;
      if ({grant, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL idle_after_reset[%0d]: got grant=%h sel=%0d valid=%b, need 00/0/0", i, grant, sel, valid);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 10; i++) begin
      tick(8'h01);
      n_tests++;
      if ({grant, sel, valid} !== {8'h01, 3'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got grant=%h sel=%0d valid=%b, need 01/0/1", i, grant, sel, valid);
      end
    end
    tick(8'h00);
    n_tests++;
    if ({grant, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_release: got grant=%h sel=%0d valid=%b, need 00/0/0", grant, sel, valid);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] one;
    int         o;
    one = 8'h01;
    do_reset();
    for (int t = 0; t < 8 * MAX_HOLD + MAX_HOLD; t++) begin
      tick(8'hFF);
      o = (t / MAX_HOLD) % 8;
      n_tests++;
      if ({grant, sel, valid} !== {one << o, 3'(o), 1'b1}) begin
        n_fail++;
        $display("FAIL rotation[%0d]: got grant=%h sel=%0d valid=%b, need %h/%0d/1", t, grant, sel, valid, one << o, o);
      end
    end
    tick(8'h00);
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(8'h05);
    tick(8'h05);
    n_tests++;
    if ({grant, sel, valid} !== {8'h01, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL handoff_owner0: got grant=%h sel=%0d valid=%b, need 01/0/1", grant, sel, valid);
    end
    tick(8'h04);
    n_tests++;
    if ({grant, sel, valid} !== {8'h04, 3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL handoff_no_gap: got grant=%h sel=%0d valid=%b, need 04/2/1", grant, sel, valid);
    end
    tick(8'h00);
    n_tests++;
    if ({grant, sel, valid} !== {8'h00, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL handoff_idle_sel: got grant=%h sel=%0d valid=%b, need 00/2/0", grant, sel, valid);
    end
  endtask

  task automatic test_fairness();
    tick(8'h05);
    n_tests++;
    if ({grant, sel, valid} !== {8'h01, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL fairness_wrap: got grant=%h sel=%0d valid=%b, need 01/0/1", grant, sel, valid);
    end
  endtask

  task automatic test_reset_midgrant();
    tick(8'h80);
    n_tests++;
    if ({grant, sel, valid} !== {8'h80, 3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL midgrant_owner: got grant=%h sel=%0d valid=%b, need 80/7/1", grant, sel, valid);
    end
    #1 reset = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({grant, sel, valid} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midgrant_async_clear: got grant=%h sel=%0d valid=%b, need 00/0/0", grant, sel, valid);
    end
    #1 reset = 1'b1;
    tick(8'h80);
    n_tests++;
    if ({grant, sel, valid} !== {8'h80, 3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL midgrant_restart: got grant=%h sel=%0d valid=%b, need 80/7/1", grant, sel, valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] eg;
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: r = 8'($urandom);
        1: r = 8'h01 << $urandom_range(0, 7);
        2: r = r;
        3: r = r | (8'h01 << $urandom_range(0, 7));
        default: r = r & 8'($urandom);
      endcase
      if ($urandom_range(0, 149) == 0) do_reset();
      tick(r);
      eg = exp_grant();
      n_tests++;
      if (grant !== eg || valid !== (m_owner >= 0) || sel !== 3'(m_sel)) begin
        n_fail++;
        $display("FAIL random[%0d] req=%h: got grant=%h sel=%0d valid=%b, need %h/%0d/%b",
                 i, r, grant, sel, valid, eg, m_sel, (m_owner >= 0));
      end
    end
  endtask

  initial begin
    req   = 8'h00;
    reset = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_fairness();
    test_reset_midgrant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux datapath between 8 single-bit requesters.
- Produces a registered one-hot grant, plus a binary select that drives the mux sel[2:0] directly.
- Bounds how long one requester can hold the mux while others wait, which guarantees fairness.
- Sits between requester logic and the mux8_1 instance it controls.

Parameters:
MAX_HOLD, 4, max consecutive cycles an owner keeps the grant while any other requester is waiting; legal range 1..255.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
req  input  8  request vector; bit i = requester i wants the mux.
grant  output  8  registered one-hot grant; all-zero when no owner.
sel  output  3  binary index of the current owner; drives mux sel.
valid  output  1  high while grant is non-zero, i.e. the mux output is owned.

Behaviour:
- Reset (reset=0, asynchronous, takes effect with no clock edge):
  - grant=8'h00, sel=3'd0, valid=0.
  - Internal pointer ptr=0, hold counter cnt=0, state IDLE.
- All other state updates on the rising edge of clk only. req is sampled at the edge.
- Latency: a request sampled at edge N appears on grant, sel and valid after edge N; outputs are registered.
- Arbitration function:
  - Scan req from index ptr upward, wrapping 7 -> 0.
  - The first set bit wins.
  - ptr is 3 bits and wraps modulo 8.
- State IDLE:
  - req==0: stay IDLE; outputs unchanged (grant 0, valid 0). sel keeps its last value.
  - req!=0: winner w. Go to GRANT; grant=1<<w, sel=w, valid=1, cnt=1, ptr=w+1.
- State GRANT, owner o:
  - req[o]==0, no other req: go to IDLE; grant=0, valid=0, sel holds o, cnt=0.
  - req[o]==0, others requesting: rearbitrate on the same edge from ptr. The new grant appears with no idle cycle; cnt=1, ptr=winner+1.
  - req[o]==1, no other req: keep the grant; cnt saturates at MAX_HOLD; no rotation.
  - req[o]==1, others requesting, cnt<MAX_HOLD: keep the grant; cnt=cnt+1.
  - req[o]==1, others requesting, cnt==MAX_HOLD: force rotation.
    - Arbitrate from ptr (=o+1), so every other requester is checked before o.
    - New owner gets the grant; cnt=1, ptr=winner+1.
- ptr changes only when a new grant is issued.
- Invariants:
  - grant is always zero or one-hot.
  - valid == (grant!=0).
  - When valid=1, sel equals the index of the set grant bit.
  - At most one grant change per cycle.
- Glitches on req between clock edges have no effect.
- Reset asserted mid-grant: outputs clear immediately. After release, arbitration restarts at ptr=0.

Test Plan:
1. Hold reset low, drive req=8'hFF -> grant=8'h00, sel=0, valid=0 with no clock edge needed. Release reset, req=0 for 5 cycles -> outputs unchanged.
2. req=8'h01 held 10 cycles -> one edge later grant=8'h01, sel=0, valid=1. Grant stays for all 10 cycles: no competitor, so no forced rotation.
3. MAX_HOLD=4, req=8'hFF constant -> grant sequence 01,02,04,...,80,01. Each owner holds exactly 4 cycles; sel follows 0..7 and wraps to 0.
4. req=8'h05, owner 0 granted, then req=8'h04 after 2 cycles -> next edge grant=8'h04, sel=2, valid stays 1 with no gap. Then req=8'h00 -> grant=0, valid=0, sel stays 2.
5. Fairness: after owner 2 releases (ptr=3), drive req=8'h05 -> grant=8'h01, sel=0. The scan runs 3..7 then 0, so 0 wins over 2.
6. Pull reset low mid-grant with req=8'h80 asserted -> outputs clear asynchronously. Release reset -> next edge grant=8'h80, sel=7, valid=1.
